// File: rtl/jtag_host_shifter.sv
// JTAG host: runs TAP-reset, IR-scan and DR-scan sequences from valid/ready commands and returns captured TDO.
// Optional build macro JTAG_HOST_LOOPBACK_EN adds lb_en, which feeds the registered tdi back into the capture path.
module jtag_host_shifter #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef JTAG_HOST_LOOPBACK_EN
    input  logic                         lb_en,
`endif
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [MAX_LEN-1:0]           rsp_data,
    output logic                         tck,
    output logic                         tms,
    output logic                         tdi,
    input  logic                         tdo,
    output logic                         busy
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = (LW > 3) ? LW : 3;
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, RST_SEQ, PRE, SHIFT, POST, WAIT_RSP} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [DW-1:0]      div_cnt_reg;
    logic               tck_reg, tms_reg, tms_next, tdi_reg, tdi_next;
    logic [LW-1:0]      len_reg, len_clamp;
    logic [CW-1:0]      len_ext;
    logic [MAX_LEN-1:0] data_reg, rsp_data_reg;
    logic               is_ir_reg, rsp_after_reg;
    logic               running, tick, tck_rise, tck_fall, step_last, sample;

    // TMS value for position c of a given state, counted in TCKs from the state's start.
    function automatic logic tms_of(state_t st, logic [CW-1:0] c, logic ir, logic [CW-1:0] ln);
        tms_of = 1'b1;
        case (st)
            RST_SEQ: tms_of = (c < CW'(5));
            PRE:     tms_of = ir ? (c < CW'(2)) : (c == CW'(0));
            SHIFT:   tms_of = (c == ln - CW'(1));
            POST:    tms_of = (c == CW'(0));
            default: tms_of = 1'b1;
        endcase
    endfunction

    assign running  = (state_reg == RST_SEQ) || (state_reg == PRE) ||
                      (state_reg == SHIFT) || (state_reg == POST);
    assign tick     = running && (div_cnt_reg == DW'(CLK_DIV - 1));
    assign tck_rise = tick && !tck_reg;
    assign tck_fall = tick && tck_reg;
    assign len_ext  = CW'(len_reg);

`ifdef JTAG_HOST_LOOPBACK_EN
    assign sample = lb_en ? tdi_reg : tdo;
`else
    assign sample = tdo;
`endif

    always_comb begin
        len_clamp = cmd_len;
        if (cmd_len == '0)
            len_clamp = LW'(1);
        else if (cmd_len > LW'(MAX_LEN))
            len_clamp = LW'(MAX_LEN);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tms_next   = tms_reg;
        tdi_next   = tdi_reg;
        step_last  = 1'b0;
        case (state_reg)
            RST_SEQ: step_last = (cnt_reg == CW'(5));
            PRE:     step_last = (cnt_reg == (is_ir_reg ? CW'(3) : CW'(2)));
            SHIFT:   step_last = (cnt_reg == len_ext - CW'(1));
            POST:    step_last = (cnt_reg == CW'(1));
            default: step_last = 1'b0;
        endcase
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    // Every sequence starts with TMS=1 from Run-Test/Idle, so it is set while tck is low.
                    state_next = cmd_op[1] ? RST_SEQ : PRE;
                    cnt_next   = '0;
                    tms_next   = 1'b1;
                    tdi_next   = 1'b0;
                end
            end
            WAIT_RSP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: begin
                if (tck_fall) begin
                    if (!step_last) begin
                        cnt_next = cnt_reg + CW'(1);
                    end else begin
                        cnt_next = '0;
                        case (state_reg)
                            RST_SEQ: state_next = rsp_after_reg ? WAIT_RSP : IDLE;
                            PRE:     state_next = SHIFT;
                            SHIFT:   state_next = POST;
                            default: state_next = WAIT_RSP;
                        endcase
                    end
                    if ((state_next == IDLE) || (state_next == WAIT_RSP)) begin
                        tdi_next = 1'b0;
                    end else begin
                        tms_next = tms_of(state_next, cnt_next, is_ir_reg, len_ext);
                        tdi_next = (state_next == SHIFT) &&
                                   |(data_reg & (MAX_LEN'(1) << cnt_next));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RST_SEQ;
            cnt_reg       <= '0;
            div_cnt_reg   <= '0;
            tck_reg       <= 1'b0;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            len_reg       <= LW'(1);
            data_reg      <= '0;
            rsp_data_reg  <= '0;
            is_ir_reg     <= 1'b0;
            rsp_after_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tms_reg   <= tms_next;
            tdi_reg   <= tdi_next;
            if (state_reg == IDLE) begin
                div_cnt_reg <= '0;
                tck_reg     <= 1'b0;
                if (cmd_valid) begin
                    len_reg       <= len_clamp;
                    data_reg      <= cmd_data;
                    is_ir_reg     <= (cmd_op == 2'd1);
                    rsp_after_reg <= 1'b1;
                    rsp_data_reg  <= '0;
                end
            end else if (running) begin
                div_cnt_reg <= tick ? '0 : div_cnt_reg + DW'(1);
                if (tick)
                    tck_reg <= !tck_reg;
                // Target drives TDO on the falling edge, so it is stable at our rise.
                if (tck_rise && (state_reg == SHIFT))
                    rsp_data_reg <= rsp_data_reg | (MAX_LEN'(sample) << cnt_reg);
            end
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == WAIT_RSP);
    assign busy      = (state_reg != IDLE);
    assign rsp_data  = rsp_data_reg;
    assign tck       = tck_reg;
    assign tms       = tms_reg;
    assign tdi       = tdi_reg;
endmodule

// File: tb/tb_jtag_host_shifter.sv
// Bench for jtag_host_shifter: behavioural TAP target (8-bit IR, IDCODE and BYPASS DRs) plus directed vectors.
module tb_jtag_host_shifter;
    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 4;
    localparam int LW = 6;
    localparam logic [31:0] IDCODE = 32'h149511C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              cmd_valid = 1'b0, cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [LW-1:0]     cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic              rsp_valid, rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic              tck, tms, tdi, busy;
    logic              tdo = 1'b0;

    jtag_host_shifter #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef JTAG_HOST_LOOPBACK_EN
        .lb_en(1'b0),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .tck(tck), .tms(tms),
        .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    // Target TAP model.
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR} tap_t;
    tap_t        tap_st = TLR;
    logic [7:0]  tap_ir = 8'h02, ir_sr = '0;
    logic [31:0] idc_sr = '0;
    logic        byp = 1'b0;

    always @(posedge tck) begin
        case (tap_st)
            TLR:   tap_ir <= 8'h02;
            CAPDR: begin idc_sr <= IDCODE; byp <= 1'b0; end
            SHDR:  if (tap_ir == 8'h02) idc_sr <= {tdi, idc_sr[31:1]}; else byp <= tdi;
            CAPIR: ir_sr <= 8'h01;
            SHIR:  ir_sr <= {tdi, ir_sr[7:1]};
            UPDIR: tap_ir <= ir_sr;
            default: ;
        endcase
        case (tap_st)
            TLR:   tap_st <= tms ? TLR   : RTI;
            RTI:   tap_st <= tms ? SELDR : RTI;
            SELDR: tap_st <= tms ? SELIR : CAPDR;
            CAPDR: tap_st <= tms ? EX1DR : SHDR;
            SHDR:  tap_st <= tms ? EX1DR : SHDR;
            EX1DR: tap_st <= tms ? UPDDR : PAUDR;
            PAUDR: tap_st <= tms ? EX2DR : PAUDR;
            EX2DR: tap_st <= tms ? UPDDR : SHDR;
            UPDDR: tap_st <= tms ? SELDR : RTI;
            SELIR: tap_st <= tms ? TLR   : CAPIR;
            CAPIR: tap_st <= tms ? EX1IR : SHIR;
            SHIR:  tap_st <= tms ? EX1IR : SHIR;
            EX1IR: tap_st <= tms ? UPDIR : PAUIR;
            PAUIR: tap_st <= tms ? EX2IR : PAUIR;
            EX2IR: tap_st <= tms ? UPDIR : SHIR;
            default: tap_st <= tms ? SELDR : RTI;
        endcase
    end

    always @(negedge tck) begin
        if (tap_st == SHDR)      tdo <= (tap_ir == 8'h02) ? idc_sr[0] : byp;
        else if (tap_st == SHIR) tdo <= ir_sr[0];
        else                     tdo <= 1'b0;
    end

    // TCK rise counter and TMS history seen at each rise.
    int   rise_total = 0;
    logic tms_hist [4096];
    always @(posedge tck) begin
        tms_hist[rise_total % 4096] <= tms;
        rise_total <= rise_total + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] tms_seq(input int start, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++) v[i] = tms_hist[(start + i) % 4096];
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tck"}, 64'(tck), 64'd0);
        chk({tag, "_tms"}, 64'(tms), 64'd1);
        chk({tag, "_tdi"}, 64'(tdi), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_cmd_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL %s: got timeout expected cmd_ready=1", name);
        end
    endtask

    // Power-up / abort recovery: expect the 6-TCK reset sequence with no response.
    task automatic check_reset_seq(input string tag);
        int start = rise_total;
        int n = 0;
        bit seen = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk); n++;
            seen |= rsp_valid;
        end
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_rises"}, 64'(rise_total - start), 64'd6);
        chk({tag, "_tms"}, tms_seq(start, 6), 64'h1F);
        chk({tag, "_no_rsp"}, 64'(seen), 64'd0);
        chk({tag, "_tck_low"}, 64'(tck), 64'd0);
        $display("reset_seq %s rises=%0d", tag, rise_total - start);
    endtask

    task automatic do_scan(input logic [1:0] op, input logic [LW-1:0] len, input logic [31:0] data,
                           input bit hold, output logic [31:0] rsp, output int rises, output int start);
        int n = 0;
        wait_cmd_ready("cmd_ready_wait");
        start = rise_total;
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_wait: got timeout expected rsp_valid=1");
        end
        rsp = rsp_data;
        rises = rise_total - start;
        if (!hold) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        $display("txn op=%0d len=%0d data=%h rsp=%h tck_rises=%0d", op, len, data, rsp, rises);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [LW-1:0] len;
        logic [31:0]   data;
        logic [31:0]   exp_rsp;
        int            exp_rises;
        bit            chk_tms;
        logic [63:0]   exp_tms;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rsp;
        int rises, start, n;
        bit ok;

        vecs[0]  = '{2'd1, 6'd8,  32'h02,       32'h01,       14, 1'b1, 64'h1803};
        vecs[1]  = '{2'd0, 6'd32, 32'h0,        IDCODE,       37, 1'b1, 64'h0000_000C_0000_0001};
        vecs[2]  = '{2'd0, 6'd8,  32'h0,        32'hC3,       13, 1'b0, 64'h0};
        vecs[3]  = '{2'd0, 6'd0,  32'h0,        32'h1,        6,  1'b0, 64'h0};
        vecs[4]  = '{2'd0, 6'd40, 32'h0,        IDCODE,       37, 1'b0, 64'h0};
        vecs[5]  = '{2'd1, 6'd8,  32'hFF,       32'h01,       14, 1'b0, 64'h0};
        vecs[6]  = '{2'd0, 6'd8,  32'hA5,       32'h4A,       13, 1'b0, 64'h0};
        vecs[7]  = '{2'd0, 6'd32, 32'hDEADBEEF, 32'hBD5B7DDE, 37, 1'b0, 64'h0};
        vecs[8]  = '{2'd2, 6'd8,  32'hFFFF,     32'h0,        6,  1'b1, 64'h1F};
        vecs[9]  = '{2'd0, 6'd16, 32'h0,        32'h11C3,     21, 1'b0, 64'h0};
        vecs[10] = '{2'd3, 6'd5,  32'h3,        32'h0,        6,  1'b0, 64'h0};
        vecs[11] = '{2'd0, 6'd1,  32'h1,        32'h1,        6,  1'b0, 64'h0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_seq("por");

        for (int i = 0; i < 12; i++) begin
            do_scan(vecs[i].op, vecs[i].len, vecs[i].data, 1'b0, rsp, rises, start);
            chk($sformatf("v%0d_rsp", i), 64'(rsp), 64'(vecs[i].exp_rsp));
            chk($sformatf("v%0d_rises", i), 64'(rises), 64'(vecs[i].exp_rises));
            if (vecs[i].chk_tms)
                chk($sformatf("v%0d_tms", i), tms_seq(start, rises), vecs[i].exp_tms);
            if (vecs[i].op == 2'd1)
                chk($sformatf("v%0d_tap_ir", i), 64'(tap_ir), 64'(vecs[i].data[7:0]));
        end

        // Response held while rsp_ready stays low (bypass active from vector 5 is gone after reset; reload it).
        do_scan(2'd1, 6'd8, 32'hFF, 1'b0, rsp, rises, start);
        do_scan(2'd0, 6'd8, 32'h3C, 1'b1, rsp, rises, start);
        chk("hold_first_rsp", 64'(rsp), 64'h78);
        ok = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 32'h78 || cmd_ready || tck) ok = 0;
        end
        chk("hold_stable", 64'(ok), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_release_valid", 64'(rsp_valid), 64'd0);
        chk("hold_release_ready", 64'(cmd_ready), 64'd1);
        $display("txn hold rsp=%h released", rsp);

        // Abort at shift bit 10 of a 32-bit DR scan (with BYPASS loaded so recovery is observable).
        do_scan(2'd1, 6'd8, 32'hFF, 1'b0, rsp, rises, start);
        wait_cmd_ready("abort_ready");
        start = rise_total;
        cmd_op = 2'd0; cmd_len = 6'd32; cmd_data = 32'h12345678; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while ((rise_total - start) < 13 && n < 5000) begin @(negedge clk); n++; end
        chk("abort_point", 64'(rise_total - start), 64'd13);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        ok = 1;
        repeat (3) begin @(negedge clk); if (rsp_valid) ok = 0; end
        chk("abort_no_rsp", 64'(ok), 64'd1);
        rst_n = 1'b1;
        check_reset_seq("abort");
        do_scan(2'd0, 6'd32, 32'h0, 1'b0, rsp, rises, start);
        chk("post_abort_idcode", 64'(rsp), 64'(IDCODE));
        chk("post_abort_rises", 64'(rises), 64'd37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
